// File: rtl/result_display_pkg.sv
// Shared types and helpers for the result display sequencer and its hold timer.
package result_display_pkg;

    // Top-level sequencing states: capture a set, present it, then flag completion.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width that never collapses to zero bits for tiny counts.
    function automatic int safeWidth(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Free-running hold counter with enable and clear. Pulses o_tick on the cycle
// it sits at its terminal count, then wraps to zero on the following edge.
module hold_timer
    import result_display_pkg::*;
#(
    parameter int hold_cycles_p = 60000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CntW = safeWidth(hold_cycles_p);
    localparam logic [CntW-1:0] LastCount = CntW'(hold_cycles_p - 1);

    logic [CntW-1:0] r_count;

    // Clear has priority so a held clear freezes the count at zero.
    assign o_tick = i_enable && !i_clear && (r_count == LastCount);

    // Count enabled cycles, wrapping after the terminal count.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (r_count == LastCount) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/result_display_sequencer.sv
// Captures one set of depth_p result words from a valid/ready stream, then
// presents them one by one, advancing on a hold timer (auto) or a step pulse
// (manual), optionally looping, and re-arms for the next set.
module result_display_sequencer
    import result_display_pkg::*;
#(
    parameter int width_p       = 8,
    parameter int depth_p       = 4,
    parameter int hold_cycles_p = 60000000
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              valid_i,
    input  logic [width_p-1:0]                data_i,
    output logic                              ready_o,
    input  logic                              mode_i,
    input  logic                              step_i,
    input  logic                              loop_i,
    output logic [width_p-1:0]                data_o,
    output logic [safeWidth(depth_p)-1:0]     index_o,
    output logic                              show_o,
    output logic                              done_o
);

    localparam int IdxW = safeWidth(depth_p);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(depth_p - 1);

    state_e               r_state;
    logic [IdxW-1:0]      r_wptr;
    logic [IdxW-1:0]      r_index;
    logic [width_p-1:0]   r_buf [depth_p];
    logic [width_p-1:0]   r_data;
    logic                 r_ready;
    logic                 r_show;
    logic                 r_done;

    logic                 w_write;
    logic                 w_tick;
    logic                 w_timerEnable;
    logic                 w_timerClear;
    logic                 w_advance;
    logic [IdxW-1:0]      w_nextIndex;

    // Words are only accepted while filling, so a set being shown is never overwritten.
    assign w_write       = (r_state == FILL) && valid_i;
    // Manual mode holds the timer at zero, so returning to auto starts a full hold.
    assign w_timerEnable = (r_state == SHOW) && !mode_i;
    assign w_timerClear  = (r_state != SHOW) || mode_i;
    assign w_advance     = (r_state == SHOW) && (mode_i ? step_i : w_tick);
    assign w_nextIndex   = r_index + IdxW'(1);

    hold_timer #(
        .hold_cycles_p(hold_cycles_p)
    ) u_holdTimer (
        .i_clk    (clk_i),
        .i_reset  (reset_i),
        .i_enable (w_timerEnable),
        .i_clear  (w_timerClear),
        .o_tick   (w_tick)
    );

    // Result buffer: plain registers, contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_write) begin
            r_buf[r_wptr] <= data_i;
        end
    end

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= FILL;
            r_wptr  <= '0;
            r_index <= '0;
            r_data  <= '0;
            r_ready <= 1'b1;
            r_show  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_write) begin
                        if (r_wptr == LastIdx) begin
                            r_state <= SHOW;
                            r_wptr  <= '0;
                            r_index <= '0;
                            r_data  <= r_buf[0];
                            r_ready <= 1'b0;
                            r_show  <= 1'b1;
                        end else begin
                            r_wptr <= r_wptr + IdxW'(1);
                        end
                    end
                end
                SHOW: begin
                    if (w_advance) begin
                        if (r_index != LastIdx) begin
                            r_index <= w_nextIndex;
                            r_data  <= r_buf[w_nextIndex];
                        end else if (loop_i) begin
                            r_index <= '0;
                            r_data  <= r_buf[0];
                        end else begin
                            r_state <= DONE;
                            r_index <= '0;
                            r_data  <= '0;
                            r_show  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= FILL;
                    r_wptr  <= '0;
                    r_index <= '0;
                    r_data  <= '0;
                    r_ready <= 1'b1;
                    r_show  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= FILL;
                    r_wptr  <= '0;
                    r_index <= '0;
                    r_data  <= '0;
                    r_ready <= 1'b1;
                    r_show  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign data_o  = r_data;
    assign index_o = r_index;
    assign show_o  = r_show;
    assign done_o  = r_done;

endmodule
